stopwatch_count: RTL and testbench

- BCD stopwatch core: keeps MM:SS as four BCD digits (min1 min0 : sec1 sec0), range 00:00 to 99:59.
- Advances once per second in normal mode and supports pause and manual adjust.
- Sits between the debounced button/switch inputs and the 7-segment display driver.
- Generates its own 1 Hz and 2 Hz enable ticks from the system clock; it has no other clock domains.

---
 rtl/stopwatch_count.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_count.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_count.sv
// BCD MM:SS stopwatch core with internal 1 Hz count and 2 Hz adjust enables.
// Supports pause toggle, per-field adjust up/down, and hold.
module stopwatch_count #(
    parameter int unsigned ONE_HZ_DIV = 100_000_000,
    parameter int unsigned ADJ_DIV    = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic [1:0] adjust,
    input  logic       select,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0
);

    localparam int unsigned Div1W = (ONE_HZ_DIV > 1) ? $clog2(ONE_HZ_DIV) : 1;
    localparam int unsigned Div2W = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
    localparam logic [Div1W-1:0] Div1Max = Div1W'(ONE_HZ_DIV - 1);
    localparam logic [Div2W-1:0] Div2Max = Div2W'(ADJ_DIV - 1);

    typedef enum logic [1:0] {
        ModeNormal = 2'b00,
        ModeUp     = 2'b01,
        ModeDown   = 2'b10,
        ModeHold   = 2'b11
    } mode_e;

    typedef enum logic [0:0] {
        StRun,
        StPaused
    } state_e;

    // Tens digit in [7:4], units digit in [3:0].
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] tens_max);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == tens_max) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [3:0] tens_max);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            r[7:4] = (v[7:4] == 4'd0) ? tens_max : v[7:4] - 4'd1;
        end else begin
            r[3:0] = v[3:0] - 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    logic [Div1W-1:0] div1_q, div1_d;
    logic [Div2W-1:0] div2_q, div2_d;
    logic             tick1, tick2;
    logic             pause_q;
    logic             pause_rise;
    state_e           state_q, state_d;
    logic             count_en;
    mode_e            mode;
    logic [7:0]       sec_q, sec_d;
    logic [7:0]       min_q, min_d;

    // Enable tick dividers; both free-run in every mode.
    always_comb begin
        tick1  = (div1_q == Div1Max);
        tick2  = (div2_q == Div2Max);
        div1_d = tick1 ? '0 : div1_q + Div1W'(1);
        div2_d = tick2 ? '0 : div2_q + Div2W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div1_q  <= '0;
            div2_q  <= '0;
            pause_q <= 1'b0;
        end else begin
            div1_q  <= div1_d;
            div2_q  <= div2_d;
            pause_q <= pause;
        end
    end

    assign pause_rise = pause & ~pause_q;

    // Run/paused FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Run/paused FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (pause_rise) state_d = StPaused;
            StPaused: if (pause_rise) state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    // Run/paused FSM: output uses the pre-toggle state.
    always_comb begin
        count_en = (state_q == StRun);
    end

    assign mode = mode_e'(adjust);

    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        unique case (mode)
            ModeNormal: begin
                if (tick1 && count_en) begin
                    sec_d = bcd_inc(sec_q, 4'd5);
                    if (sec_q == 8'h59) begin
                        min_d = bcd_inc(min_q, 4'd9);
                    end
                end
            end
            ModeUp: begin
                if (tick2) begin
                    if (select) sec_d = bcd_inc(sec_q, 4'd5);
                    else        min_d = bcd_inc(min_q, 4'd9);
                end
            end
            ModeDown: begin
                if (tick2) begin
                    if (select) sec_d = bcd_dec(sec_q, 4'd5);
                    else        min_d = bcd_dec(min_q, 4'd9);
                end
            end
            ModeHold: begin
                sec_d = sec_q;
                min_d = min_q;
            end
            default: begin
                sec_d = sec_q;
                min_d = min_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q <= 8'h00;
            min_q <= 8'h00;
        end else begin
            sec_q <= sec_d;
            min_q <= min_d;
        end
    end

    assign min1 = min_q[7:4];
    assign min0 = min_q[3:0];
    assign sec1 = sec_q[7:4];
    assign sec0 = sec_q[3:0];

endmodule

// File: tb/tb_stopwatch_count.sv
// Bench for stopwatch_count: directed scenarios plus random stimulus, checked against
// a seconds/minutes arithmetic model.
module tb_stopwatch_count;

    localparam int unsigned D1 = 4;
    localparam int unsigned D2 = 2;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       pause  = 1'b0;
    logic [1:0] adjust = 2'b00;
    logic       select = 1'b0;
    logic [3:0] min1, min0, sec1, sec0;

    int passes = 0;
    int total  = 0;

    // Reference model state.
    int m_min    = 0;
    int m_sec    = 0;
    int m_n      = 0;
    bit m_paused = 1'b0;
    bit m_pprev  = 1'b0;

    stopwatch_count #(
        .ONE_HZ_DIV(D1),
        .ADJ_DIV   (D2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pause (pause),
        .adjust(adjust),
        .select(select),
        .min1  (min1),
        .min0  (min0),
        .sec1  (sec1),
        .sec0  (sec0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        logic [15:0] got;
        got = {min1, min0, sec1, sec0};
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_edge(input bit rst, input bit p, input bit [1:0] adj, input bit sel);
        bit t1, t2;
        if (rst) begin
            m_n = 0; m_min = 0; m_sec = 0; m_paused = 1'b0; m_pprev = 1'b0;
        end else begin
            m_n++;
            t1 = (m_n % D1) == 0;
            t2 = (m_n % D2) == 0;
            case (adj)
                2'b00: if (t1 && !m_paused) begin
                    m_sec++;
                    if (m_sec == 60) begin
                        m_sec = 0;
                        m_min = (m_min + 1) % 100;
                    end
                end
                2'b01: if (t2) begin
                    if (sel) m_sec = (m_sec + 1) % 60;
                    else     m_min = (m_min + 1) % 100;
                end
                2'b10: if (t2) begin
                    if (sel) m_sec = (m_sec + 59) % 60;
                    else     m_min = (m_min + 99) % 100;
                end
                default: ;
            endcase
            if (p && !m_pprev) m_paused = !m_paused;
            m_pprev = p;
        end
    endtask

    task automatic step(input bit rst, input bit p, input bit [1:0] adj, input bit sel);
        reset  = rst;
        pause  = p;
        adjust = adj;
        select = sel;
        @(posedge clk);
        model_edge(rst, p, adj, sel);
        #1;
        check("model", enc(m_min, m_sec));
    endtask

    task automatic run(input int n, input bit p, input bit [1:0] adj, input bit sel);
        for (int i = 0; i < n; i++) step(1'b0, p, adj, sel);
    endtask

    initial begin
        bit       r_rst, r_p, r_sel;
        bit [1:0] r_adj;

        step(1'b1, 1'b0, 2'b00, 1'b0);
        check("reset", 16'h0000);
        run(40, 1'b0, 2'b00, 1'b0);
        check("ten_sec", 16'h0010);
        run(200, 1'b0, 2'b00, 1'b0);
        check("one_min", 16'h0100);

        // Preload 99:59 and roll over.
        step(1'b1, 1'b0, 2'b00, 1'b0);
        run(2, 1'b0, 2'b10, 1'b0);
        check("pre_99_00", 16'h9900);
        run(2, 1'b0, 2'b10, 1'b1);
        check("pre_99_59", 16'h9959);
        run(4, 1'b0, 2'b00, 1'b0);
        check("wrap_9959", 16'h0000);

        step(1'b1, 1'b0, 2'b00, 1'b0);
        run(18, 1'b0, 2'b01, 1'b0);
        run(2, 1'b0, 2'b10, 1'b1);
        check("pre_09_59", 16'h0959);
        run(4, 1'b0, 2'b00, 1'b0);
        check("carry_1000", 16'h1000);

        step(1'b1, 1'b0, 2'b00, 1'b0);
        run(18, 1'b0, 2'b01, 1'b1);
        check("pre_00_09", 16'h0009);
        run(4, 1'b0, 2'b00, 1'b0);
        check("carry_0010", 16'h0010);

        // Pause pulse, resume, held pause.
        step(1'b1, 1'b0, 2'b00, 1'b0);
        run(8, 1'b0, 2'b00, 1'b0);
        check("pre_pause", 16'h0002);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        run(12, 1'b0, 2'b00, 1'b0);
        check("paused", 16'h0002);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        run(7, 1'b0, 2'b00, 1'b0);
        check("resumed", 16'h0004);
        run(10, 1'b1, 2'b00, 1'b0);
        run(8, 1'b0, 2'b00, 1'b0);
        check("held_pause", 16'h0004);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        run(8, 1'b0, 2'b00, 1'b0);

        // Field adjust wraps without carry.
        step(1'b1, 1'b0, 2'b00, 1'b0);
        run(116, 1'b0, 2'b01, 1'b1);
        check("pre_00_58", 16'h0058);
        run(4, 1'b0, 2'b01, 1'b1);
        check("sec_wrap_up", 16'h0000);
        run(2, 1'b0, 2'b10, 1'b0);
        check("min_wrap_down", 16'h9900);
        run(20, 1'b0, 2'b11, 1'b0);
        check("hold", 16'h9900);
        run(4, 1'b0, 2'b00, 1'b0);
        check("hold_resume", 16'h9901);

        // Reset mid-count while paused.
        step(1'b1, 1'b0, 2'b00, 1'b0);
        run(74, 1'b0, 2'b01, 1'b0);
        run(84, 1'b0, 2'b01, 1'b1);
        check("pre_37_42", 16'h3742);
        step(1'b0, 1'b1, 2'b00, 1'b0);
        step(1'b1, 1'b1, 2'b00, 1'b0);
        check("reset_mid", 16'h0000);
        run(4, 1'b0, 2'b00, 1'b0);
        check("run_after_reset", 16'h0001);

        // Reset coinciding with tick1 and a pause edge.
        run(3, 1'b0, 2'b00, 1'b0);
        step(1'b1, 1'b1, 2'b00, 1'b0);
        check("reset_tick", 16'h0000);
        run(4, 1'b0, 2'b00, 1'b0);
        check("running_after_reset", 16'h0001);

        // Random stimulus against the model.
        r_adj = 2'b00;
        r_sel = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_p   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) begin
                r_adj = 2'($urandom_range(0, 3));
                r_sel = 1'($urandom_range(0, 1));
            end
            step(r_rst, r_p, r_adj, r_sel);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
